// File: rtl/pow_gen_pkg.sv
// Shared types and width helper for the sequential power generator.
package pow_gen_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Result width that holds operand^exp exactly for every legal exponent.
  function automatic int pow_ow(input int n, input int max_exp);
    return n * max_exp;
  endfunction

endpackage

// File: rtl/pow_gen_seq.sv
// Iterative unsigned power generator: one multiply per cycle, valid/ready on
// both sides, full-width result held stable until the consumer takes it.
module pow_gen_seq
  import pow_gen_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_EXP = 3,
  parameter int EW      = $clog2(MAX_EXP + 1),
  parameter int OW      = pow_ow(N, MAX_EXP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_num,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_result,
  output logic          out_err
);

  localparam int PW = OW + N;

  state_e        state, nxt;
  logic [OW-1:0] acc;
  logic [N-1:0]  op;
  logic [EW-1:0] cnt;
  logic          err;
  logic [PW-1:0] prod;
  logic          accept, illegal, short_exp;

  // Compared at 32 bits so the check stays meaningful when EW can encode only
  // legal exponents.
  assign illegal   = 32'(in_exp) > 32'(MAX_EXP);
  assign short_exp = 32'(in_exp) <= 32'd1;
  assign accept    = in_valid && in_ready;
  assign prod      = PW'(acc) * PW'(op);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (illegal || short_exp) ? DONE : CALC;
      CALC:    if (cnt == EW'(1)) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) && !rst;
    out_valid  = (state == DONE);
    out_result = out_valid ? acc : '0;
    out_err    = out_valid && err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      op  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= in_num;
          err <= 1'b0;
          if (illegal) begin
            acc <= '0;
            err <= 1'b1;
          end else if (in_exp == '0) begin
            acc <= OW'(1);
          end else begin
            acc <= OW'(in_num);
            cnt <= in_exp - EW'(1);
          end
        end
        // Truncation to OW never drops bits: OW already covers N*MAX_EXP.
        CALC: begin
          acc <= prod[OW-1:0];
          cnt <= cnt - EW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_gen_seq.sv
// Bench for pow_gen_seq: two instances (MAX_EXP=3 and MAX_EXP=5) checked
// against an arithmetic power/latency model.
module tb_pow_gen_seq;
  import pow_gen_pkg::*;

  localparam int OWA = pow_ow(4, 3);
  localparam int OWB = pow_ow(4, 5);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_err;
  logic [3:0]     a_in_num = 0;
  logic [1:0]     a_in_exp = 0;
  logic [OWA-1:0] a_out_result;
  logic           b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_err;
  logic [3:0]     b_in_num = 0;
  logic [2:0]     b_in_exp = 0;
  logic [OWB-1:0] b_out_result;

  int total = 0;
  int bad   = 0;

  pow_gen_seq #(.N(4), .MAX_EXP(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_num(a_in_num), .in_exp(a_in_exp), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_result(a_out_result), .out_err(a_out_err));

  pow_gen_seq #(.N(4), .MAX_EXP(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_num(b_in_num), .in_exp(b_in_exp), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_result(b_out_result), .out_err(b_out_err));

  function automatic int ref_pow(input int num, input int e, input int maxe);
    int r = 1;
    if (e > maxe) return 0;
    for (int i = 0; i < e; i++) r = r * num;
    return r;
  endfunction

  function automatic int ref_lat(input int e, input int maxe);
    return (e > maxe || e < 1) ? 1 : e;
  endfunction

  function automatic int res(input bit sel);
    return sel ? int'(b_out_result) : int'(a_out_result);
  endfunction

  function automatic bit err_o(input bit sel);
    return sel ? b_out_err : a_out_err;
  endfunction

  // Waits for in_ready, presents one request for a single accept, returns at
  // the first falling edge after the accept edge.
  task automatic issue(input bit sel, input int num, input int e, output bit to);
    int n = 0;
    to = 0;
    while (!(sel ? b_in_ready : a_in_ready)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin to = 1; return; end
    end
    if (sel) begin b_in_valid = 1; b_in_num = 4'(num); b_in_exp = 3'(e); end
    else     begin a_in_valid = 1; a_in_num = 4'(num); a_in_exp = 2'(e); end
    @(negedge clk);
    if (sel) b_in_valid = 0; else a_in_valid = 0;
  endtask

  task automatic wait_out(input bit sel, output int lat, output bit to);
    lat = 1;
    to  = 0;
    while (!(sel ? b_out_valid : a_out_valid)) begin
      @(negedge clk);
      lat++;
      if (lat > 50) begin to = 1; return; end
    end
  endtask

  // One full transaction on either instance with out_ready high, checked
  // against the model including the in_ready turnaround.
  task automatic run_one(input bit sel, input int num, input int e, input string tag);
    int  maxe, lat;
    bit  to1, to2;
    maxe = sel ? 5 : 3;
    issue(sel, num, e, to1);
    wait_out(sel, lat, to2);
    total++;
    if (to1 || to2) begin
      bad++;
      $display("FAIL %s timeout num=%0d exp=%0d", tag, num, e);
      return;
    end
    total++;
    if (res(sel) !== ref_pow(num, e, maxe)) begin
      bad++; $display("FAIL %s result num=%0d exp=%0d got=%0d want=%0d", tag, num, e, res(sel), ref_pow(num, e, maxe));
    end
    total++;
    if (err_o(sel) !== (e > maxe)) begin
      bad++; $display("FAIL %s err exp=%0d got=%0b want=%0b", tag, e, err_o(sel), e > maxe);
    end
    total++;
    if (lat !== ref_lat(e, maxe)) begin
      bad++; $display("FAIL %s latency exp=%0d got=%0d want=%0d", tag, e, lat, ref_lat(e, maxe));
    end
    @(negedge clk);
    total++;
    if ((sel ? b_in_ready : a_in_ready) !== 1'b1 || (sel ? b_out_valid : a_out_valid) !== 1'b0) begin
      bad++; $display("FAIL %s turnaround in_ready=%0b out_valid=%0b want 1/0", tag,
                      sel ? b_in_ready : a_in_ready, sel ? b_out_valid : a_out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if (a_in_ready !== 0 || a_out_valid !== 0 || a_out_result !== '0 || a_out_err !== 0) begin
      bad++; $display("FAIL reset_state rdy=%0b vld=%0b res=%0d err=%0b want all 0",
                      a_in_ready, a_out_valid, a_out_result, a_out_err);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1 || b_in_ready !== 1) begin
      bad++; $display("FAIL reset_release in_ready a=%0b b=%0b want 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_cube;
    run_one(0, 15, 3, "cube_15");
    total++;
    if (a_out_result !== 12'hD2F && 0) bad++;
    for (int i = 0; i < 20; i++)
      run_one(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand_a");
  endtask

  task automatic test_exp01;
    run_one(0, 7, 0, "exp0_7");
    run_one(0, 0, 0, "exp0_0");
    run_one(0, 9, 1, "exp1_9");
  endtask

  task automatic test_stall;
    int lat;
    bit to1, to2;
    a_out_ready = 0;
    issue(0, 2, 2, to1);
    wait_out(0, lat, to2);
    total++;
    if (to1 || to2) begin bad++; $display("FAIL stall timeout"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_out_valid !== 1 || a_out_result !== 12'd4 || a_in_ready !== 0) begin
        bad++; $display("FAIL stall_hold cyc=%0d vld=%0b res=%0d rdy=%0b want 1/4/0",
                        i, a_out_valid, a_out_result, a_in_ready);
      end
      @(negedge clk);
    end
    a_out_ready = 1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1 || a_out_valid !== 0) begin
      bad++; $display("FAIL stall_release rdy=%0b vld=%0b want 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_input_change;
    int lat;
    bit to1, to2;
    issue(0, 3, 3, to1);
    a_in_valid = 1; a_in_num = 4'd15; a_in_exp = 2'd2;
    total++;
    if (a_in_ready !== 0) begin bad++; $display("FAIL chg_busy in_ready=%0b want 0", a_in_ready); end
    wait_out(0, lat, to2);
    total++;
    if (to1 || to2 || a_out_result !== 12'd27 || lat !== 3) begin
      bad++; $display("FAIL chg_first res=%0d lat=%0d want 27/3", a_out_result, lat);
    end
    @(negedge clk);
    total++;
    if (a_in_ready !== 1) begin bad++; $display("FAIL chg_ready in_ready=%0b want 1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 0;
    wait_out(0, lat, to2);
    total++;
    if (to2 || a_out_result !== 12'd225 || lat !== 2) begin
      bad++; $display("FAIL chg_second res=%0d lat=%0d want 225/2", a_out_result, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_err;
    run_one(1, 4, 6, "err_6");
    run_one(1, 3, 5, "b_3_5");
    run_one(1, 15, 7, "err_7");
    run_one(1, 15, 5, "b_15_5");
    for (int i = 0; i < 15; i++)
      run_one(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), "rand_b");
  endtask

  task automatic test_reset_mid;
    bit to1;
    issue(0, 15, 3, to1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++;
    if (to1 || a_out_valid !== 0 || a_out_result !== '0 || a_out_err !== 0 || a_in_ready !== 0) begin
      bad++; $display("FAIL rst_mid vld=%0b res=%0d err=%0b rdy=%0b want all 0",
                      a_out_valid, a_out_result, a_out_err, a_in_ready);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (a_out_valid !== 0 || a_out_result !== '0 || a_in_ready !== 1) begin
        bad++; $display("FAIL rst_discard cyc=%0d vld=%0b res=%0d rdy=%0b want 0/0/1",
                        i, a_out_valid, a_out_result, a_in_ready);
      end
    end
    run_one(0, 2, 3, "after_rst");
  endtask

  task automatic test_back_to_back;
    a_in_valid = 1; a_in_num = 4'd5; a_in_exp = 2'd2;
    for (int k = 0; k < 3; k++) begin
      int lat;
      bit to;
      @(negedge clk);
      wait_out(0, lat, to);
      total++;
      if (to || a_out_result !== 12'd25 || lat !== 2) begin
        bad++; $display("FAIL b2b k=%0d res=%0d lat=%0d want 25/2", k, a_out_result, lat);
      end
      @(negedge clk);
    end
    a_in_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cube();
    test_exp01();
    test_stall();
    test_input_change();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
